pixel_clip_fifo: RTL and testbench

// - Sits between the circle/fill datapath's pixel outputs (x, y, colour, plot strobe)
//   and the VGA framebuffer write port (160x120, 3-bit colour).
// - Discards off-screen pixels, e.g. x wrapped by center_x - x underflow, or y > 119.
// - Buffers on-screen pixels in a small FIFO so the framebuffer side can stall

---
 rtl/pixel_clip_fifo.sv | 115 +++++++++++
 tb/tb_pixel_clip_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_clip_fifo.sv
// Clips off-screen pixels (x > XMAX or y > YMAX) and buffers the on-screen ones in a
// first-word fall-through FIFO. Optional duplicate-pixel dropping: `define PIXEL_DEDUP_EN.
module pixel_clip_fifo #(
  parameter int DEPTH = 8,
  parameter int XMAX  = 159,
  parameter int YMAX  = 119,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_x,
  output logic [6:0]               out_y,
  output logic [2:0]               out_colour,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         clipped_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [17:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  clip_q, clip_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, in_range, drop, push, pop;
  logic [17:0]       head;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // ready never depends on valid, and out_* never depend combinationally on in_*.
  assign in_ready = resetn && in_ready_q && !flush;
  assign accept   = in_valid && in_ready;
  assign in_range = (in_x <= 8'(XMAX)) && (in_y <= 7'(YMAX));
  assign pop      = (level_q != '0) && out_ready && !flush;
  assign push     = accept && in_range && !drop;

`ifdef PIXEL_DEDUP_EN
  logic [17:0] last_q;
  logic        last_v_q;

  assign drop = last_v_q && (last_q == {in_x, in_y, in_colour});

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      last_v_q <= 1'b0;
    end else if (push) begin
      last_q   <= {in_x, in_y, in_colour};
      last_v_q <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    clip_d   = clip_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // Saturating count of rejected beats; flush gates accept so none count then.
    if (accept && !in_range && (clip_q != '1)) clip_d = clip_q + CNT_W'(1);
    in_ready_d = (level_d != LW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      clip_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      clip_q     <= clip_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  assign head        = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign out_valid   = (level_q != '0);
  assign out_x       = head[17:10];
  assign out_y       = head[9:3];
  assign out_colour  = head[2:0];
  assign level       = level_q;
  assign clipped_cnt = clip_q;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Directed bench for pixel_clip_fifo: reset, clipping, full/drain, streaming wrap,
// flush and duplicate handling; output stream checked against an expected queue.
module tb_pixel_clip_fifo;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_x, out_x;
  logic [6:0]  in_y, out_y;
  logic [2:0]  in_colour, out_colour;
  logic [3:0]  level;
  logic [15:0] clipped_cnt;

  logic [17:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  bit          dd;

  pixel_clip_fifo dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
    .level(level), .clipped_cnt(clipped_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel until accepted; wr says whether it should reach the output.
  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      input bit wr);
    int t = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_colour = c;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      step();
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
    else if (wr) exp_q.push_back({x, y, c});
    step();
    in_valid = 1'b0;
  endtask

  // Output scoreboard: every popped head must match the oldest expected pixel.
  always @(negedge clk) begin
    if (resetn && !flush && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() > 0) check_eq("pix", 32'({out_x, out_y, out_colour}), 32'(exp_q.pop_front()));
      else check_eq("extra_pix", 32'(out_valid), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIXEL_DEDUP_EN
    dd = 1'b1;
`else
    dd = 1'b0;
`endif
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_colour = '0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_clipped", 32'(clipped_cnt), 32'd0);
    check_eq("rst_out_x", 32'(out_x), 32'd0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single pixel, one-cycle latency
    send(8'd10, 7'd20, 3'd3, 1'b1);
    @(negedge clk);
    check_eq("one_valid", 32'(out_valid), 32'd1);
    check_eq("one_level", 32'(level), 32'd1);
    check_eq("one_data", 32'({out_x, out_y, out_colour}), 32'({8'd10, 7'd20, 3'd3}));
    step();
    @(negedge clk);
    check_eq("one_level0", 32'(level), 32'd0);
    check_eq("one_empty", 32'(out_valid), 32'd0);
    check_eq("one_clip", 32'(clipped_cnt), 32'd0);
    step();

    // Clipping
    send(8'd160, 7'd0, 3'd0, 1'b0);
    send(8'd0, 7'd120, 3'd1, 1'b0);
    send(8'd255, 7'd50, 3'd2, 1'b0);
    @(negedge clk);
    check_eq("clip_cnt", 32'(clipped_cnt), 32'd3);
    check_eq("clip_level", 32'(level), 32'd0);
    check_eq("clip_ready", 32'(in_ready), 32'd1);
    check_eq("clip_valid", 32'(out_valid), 32'd0);
    step();

    // Fill to DEPTH, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i + 100), 7'(i + 1), 3'(i), 1'b1);
    @(negedge clk);
    check_eq("full_level", 32'(level), 32'd8);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_x = 8'd77; in_y = 7'd77; in_colour = 3'd5;
    step();
    @(negedge clk);
    check_eq("full_hold_ready", 32'(in_ready), 32'd0);
    check_eq("full_hold_level", 32'(level), 32'd8);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("drain_level", 32'(level), 32'(8 - k));
      check_eq("drain_ready", 32'(in_ready), (k == 0) ? 32'd0 : 32'd1);
      step();
    end
    @(negedge clk);
    check_eq("drain_empty", 32'(out_valid), 32'd0);
    step();

    // Continuous push+pop across pointer wrap
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1;
      in_x = 8'((i * 7) % 160); in_y = 7'((i * 5) % 120); in_colour = 3'(i % 8);
      @(negedge clk);
      check_eq("strm_ready", 32'(in_ready), 32'd1);
      if (i > 0) check_eq("strm_level", 32'(level), 32'd1);
      exp_q.push_back({in_x, in_y, in_colour});
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check_eq("strm_end_level", 32'(level), 32'd0);
    step();

    // Flush with a pixel offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i + 30), 7'(i + 40), 3'(i), 1'b1);
    @(negedge clk);
    check_eq("pre_flush_level", 32'(level), 32'd5);
    step();
    flush = 1'b1; in_valid = 1'b1; in_x = 8'd99; in_y = 7'd99; in_colour = 3'd7;
    @(negedge clk);
    check_eq("flush_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_clip", 32'(clipped_cnt), 32'd3);
    step();
    out_ready = 1'b1;
    send(8'd1, 7'd2, 3'd3, 1'b1);
    step();

    // Repeated pixels
    send(8'd5, 7'd5, 3'd1, 1'b1);
    send(8'd5, 7'd5, 3'd1, !dd);
    send(8'd5, 7'd5, 3'd2, 1'b1);
    send(8'd5, 7'd5, 3'd1, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check_eq("drain_q", 32'(exp_q.size()), 32'd0);
    check_eq("final_level", 32'(level), 32'd0);
    check_eq("total_out", 32'(n_out), dd ? 32'd37 : 32'd38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
